uart_rx: RTL and testbench
==========================

# uart_rx

Oversampling UART receiver that consumes the 16x `tick` stream from the baud-rate generator and deframes one asynchronous serial character (start bit, DBIT data bits LSB-first, one stop bit). It sits directly downstream of the baud-rate generator and upstream of the RX FIFO/interface logic. Each received character is presented as a parallel word with a one-cycle done strobe and a framing-error flag.

## Interface
- `DBIT`, 8: data bits per character; legal values 5–8.
- `SB_TICK`, 16: s_ticks spent in the stop bit; legal values 16 (1 stop), 24 (1.5), 32 (2).
- `OVS`, 16: oversampling factor; must match the generator's tick rate. Fixed at 16 in this release.
- One clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock, 100 MHz nominal.
- `reset`  in  1  asynchronous, active-high reset.
- `s_tick`  in  1  one-`clk`-wide oversampling tick at 16x baud, from the baud-rate generator.
- `rx`  in  1  raw serial line, asynchronous to `clk`, idle high.
- `dout`  out  DBIT  last received character.
- `rx_done_tick`  out  1  one-cycle strobe when `dout`/`frame_err` update.
- `frame_err`  out  1  stop bit sampled low for the character in `dout`.

## Operation
- `rx` passes through a 2-FF synchronizer, reset to 1. A falling-edge detector (previous synced value 1, current 0) drives start detection. All FSM decisions use the synced value.
- Counters:
  - `s` is the tick counter, 5 bits, wide enough for SB_TICK−1.
  - `n` is the bit counter, 3 bits.
  - `b` is the DBIT-bit shift register.
- **IDLE**: `s_tick` is ignored. On a falling edge: `s`←0, go to START.
- **START**: on `s_tick`, if `s`==7 (mid start bit):
  - synced rx==0: `s`←0, `n`←0, go to DATA.
  - synced rx==1 (glitch): return to IDLE, no strobe.
  - Otherwise `s`++.
- **DATA**: on `s_tick`, if `s`==15: `s`←0, `b`←{rx, b[DBIT-1:1]} (LSB first).
  - If `n`==DBIT−1, go to STOP. Otherwise `n`++.
  - Otherwise `s`++.
- **STOP**: on `s_tick`, if `s`==SB_TICK−1: `dout`←`b`, `frame_err`←~rx, `rx_done_tick`←1, go to IDLE. Otherwise `s`++.
- Start detection requires a fresh falling edge. A line held low (break) after a framing error does not retrigger until it returns high and falls again.
- `dout` and `frame_err` hold their values until the next completed character. There is no consumer handshake; an unread character is overwritten.
- `s_tick` together with a falling edge in IDLE: the edge is taken and the tick is not counted.

## Timing
- Reset values: `dout`=0, `rx_done_tick`=0, `frame_err`=0, FSM=IDLE, `s`=`n`=`b`=0, synchronizer=1.
- Reset asserted mid-frame aborts the frame immediately (asynchronous). No strobe is generated for the partial character.
- The synchronizer plus edge detect add 2–3 `clk` of start-bit latency. This is negligible against the 16-tick sample offset.
- Data bit k is sampled on the 16th `s_tick` after the previous sample point, i.e. near mid-bit.
- `rx_done_tick` is high for exactly one `clk`, in the cycle after the `s_tick` that completes STOP. `dout` and `frame_err` are valid in that same cycle.
- End of frame: with SB_TICK=16 the FSM re-enters IDLE about half a bit before the stop-bit end. This allows back-to-back characters with zero idle time.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP).
  - default constants DBIT=8, SB_TICK=16, OVS=16, START_MID=7.
  - This package is also consumed by the future `uart_tx`.
- Sub-module `rx_sync`: 2-FF synchronizer plus falling-edge detector, async reset to 1. It is reused by other asynchronous inputs.

## Test plan
- Sim with 16 `clk` per `s_tick`. Send 0xA5 in 8N1 → one `rx_done_tick`, `dout`=0xA5, `frame_err`=0. Strobe occurs 1 `clk` after the 16th stop-bit tick.
- Glitch: `rx` low for 4 ticks then high → FSM returns to IDLE at START `s`==7. No strobe, `dout` unchanged.
- 0x3C with the stop bit driven low, then `rx` held low for 3 bit times → one strobe, `dout`=0x3C, `frame_err`=1. No further strobe until `rx` goes high and a proper 0x11 frame follows (received correctly, `frame_err`=0).
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap → three strobes, values in order, all `frame_err`=0.
- Reset pulsed during data bit 3 of 0x96 → outputs 0, no strobe. After release, 0x5A is received correctly.
- DBIT=7, SB_TICK=32: send 0x2B → `dout`=7'h2B. Strobe is 32 ticks into the stop period.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default framing constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int DEF_DBIT    = 8;   // data bits per character
    localparam int DEF_SB_TICK = 16;  // oversampling ticks spent in the stop bit
    localparam int OVS         = 16;  // oversampling ticks per bit
    localparam int START_MID   = 7;   // tick index of mid start bit

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an idle-high async input plus a falling-edge detector.
// Latency: 2 clk to o_sync, o_fall valid in the same cycle as the new o_sync.
// Backpressure: none; free-running.
module rx_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Resynchronize the line; everything resets to the idle (high) level.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: start, DBIT data bits LSB first, stop bit.
// Latency: o_rx_done_tick one clk after the s_tick that completes the stop period.
// Backpressure: none; an unread character is overwritten by the next one.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = DEF_SB_TICK
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_s_tick,
    input  logic            i_rx,
    output logic [DBIT-1:0] o_dout,
    output logic            o_rx_done_tick,
    output logic            o_frame_err
);

    logic            w_rx;
    logic            w_fall;

    uart_state_t     r_state, w_state_nxt;
    logic [4:0]      r_s,     w_s_nxt;
    logic [2:0]      r_n,     w_n_nxt;
    logic [DBIT-1:0] r_b,     w_b_nxt;
    logic [DBIT-1:0] r_dout,  w_dout_nxt;
    logic            r_ferr,  w_ferr_nxt;
    logic            r_done,  w_done_nxt;

    rx_sync u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_rx),
        .o_sync  (w_rx),
        .o_fall  (w_fall)
    );

    // State, counters and output registers; reset aborts any frame in flight.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_dout  <= '0;
            r_ferr  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_b     <= w_b_nxt;
            r_dout  <= w_dout_nxt;
            r_ferr  <= w_ferr_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Deframing FSM: ticks are ignored in IDLE, so a tick coinciding with the edge is not counted.
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_n_nxt     = r_n;
        w_b_nxt     = r_b;
        w_dout_nxt  = r_dout;
        w_ferr_nxt  = r_ferr;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_s_nxt     = '0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (i_s_tick) begin
                    if (r_s == 5'(START_MID)) begin
                        if (!w_rx) begin
                            w_s_nxt     = '0;
                            w_n_nxt     = '0;
                            w_state_nxt = DATA;
                        end else begin
                            w_state_nxt = IDLE;  // glitch, not a real start bit
                        end
                    end else begin
                        w_s_nxt = r_s + 5'd1;
                    end
                end
            end
            DATA: begin
                if (i_s_tick) begin
                    if (r_s == 5'(OVS - 1)) begin
                        w_s_nxt = '0;
                        w_b_nxt = {w_rx, r_b[DBIT-1:1]};
                        if (r_n == 3'(DBIT - 1)) begin
                            w_state_nxt = STOP;
                        end else begin
                            w_n_nxt = r_n + 3'd1;
                        end
                    end else begin
                        w_s_nxt = r_s + 5'd1;
                    end
                end
            end
            STOP: begin
                if (i_s_tick) begin
                    if (r_s == 5'(SB_TICK - 1)) begin
                        w_dout_nxt  = r_b;
                        w_ferr_nxt  = ~w_rx;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_s_nxt = r_s + 5'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_dout         = r_dout;
    assign o_frame_err    = r_ferr;
    assign o_rx_done_tick = r_done;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: 8N1 and 7-bit/2-stop instances, table, random and corner sequences.
// Expected strobe tick = frame start tick + 8 + 16*DBIT + SB_TICK.
// Stimulus and ticks are driven on the falling clock edge; outputs sampled 1 ns after rising edge.
module tb_uart_rx;

    typedef struct {
        logic [7:0] dout;
        logic       ferr;
        int         tick;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_v;
        bit         align;
        int         gap;
        logic [7:0] exp_dout;
        logic       exp_ferr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_tick;
    logic       rx8, rx7;
    logic [7:0] dout8;
    logic [6:0] dout7;
    logic       done8, done7, ferr8, ferr7;

    int         phase;
    int         tick_num;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] last_exp8;
    exp_t       q8[$];
    exp_t       q7[$];
    vec_t       vt[5];

    always #5 clk = ~clk;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut8 (
        .i_clk(clk), .i_reset(rst), .i_s_tick(s_tick), .i_rx(rx8),
        .o_dout(dout8), .o_rx_done_tick(done8), .o_frame_err(ferr8)
    );

    uart_rx #(.DBIT(7), .SB_TICK(32)) dut7 (
        .i_clk(clk), .i_reset(rst), .i_s_tick(s_tick), .i_rx(rx7),
        .o_dout(dout7), .o_rx_done_tick(done7), .o_frame_err(ferr7)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (tick %0d)", name, act, exp, tick_num);
        end
    endtask

    // One clk: advance the tick phase; a tick is asserted every 16th clk.
    task automatic step();
        @(negedge clk);
        phase  = (phase + 1) % 16;
        s_tick = (phase == 0);
        if (s_tick) tick_num++;
    endtask

    task automatic hold_ticks(input int n);
        int k = 0;
        while (k < n) begin
            step();
            if (s_tick) k++;
        end
    endtask

    task automatic set_rx(input bit inst7, input logic v);
        if (inst7) rx7 = v;
        else       rx8 = v;
    endtask

    task automatic idle(input bit inst7, input int n);
        set_rx(inst7, 1'b1);
        hold_ticks(n);
    endtask

    // Reference model: the character is the low DBIT bits sent, error iff stop level low.
    function automatic logic [7:0] ref_char(input logic [7:0] data, input int dbit);
        return data & 8'((1 << dbit) - 1);
    endfunction

    task automatic send_frame(input bit inst7, input logic [7:0] data, input logic stop_v,
                              input int stop_ticks, input bit align,
                              input logic [7:0] exp_dout, input logic exp_ferr);
        int   dbit = inst7 ? 7 : 8;
        int   sbt  = inst7 ? 32 : 16;
        int   t0;
        exp_t e;
        if (align) begin
            // start edge is detected 2 clk after rx falls: make it coincide with a tick
            while (phase != 14) step();
            t0 = tick_num + 1;
        end else begin
            while (!s_tick) step();
            t0 = tick_num;
        end
        e.dout = exp_dout;
        e.ferr = exp_ferr;
        e.tick = t0 + 8 + 16 * dbit + sbt;
        if (inst7) q7.push_back(e);
        else       q8.push_back(e);
        if (!inst7) last_exp8 = exp_dout;
        set_rx(inst7, 1'b0);
        hold_ticks(16);
        for (int i = 0; i < dbit; i++) begin
            set_rx(inst7, data[i]);
            hold_ticks(16);
        end
        set_rx(inst7, stop_v);
        hold_ticks(stop_ticks);
    endtask

    // Scoreboard for the 8-bit instance.
    initial begin : mon8
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done8 === 1'b1) begin
                if (q8.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_strobe8: done=1, required 0 (tick %0d)", tick_num);
                end else begin
                    e = q8.pop_front();
                    check("dout8", 32'(dout8), 32'(e.dout));
                    check("ferr8", 32'(ferr8), 32'(e.ferr));
                    check("strobe_tick8", 32'(tick_num), 32'(e.tick));
                end
            end
        end
    end

    // Scoreboard for the 7-bit / 2-stop instance.
    initial begin : mon7
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done7 === 1'b1) begin
                if (q7.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_strobe7: done=1, required 0 (tick %0d)", tick_num);
                end else begin
                    e = q7.pop_front();
                    check("dout7", 32'(dout7), 32'(e.dout));
                    check("ferr7", 32'(ferr7), 32'(e.ferr));
                    check("strobe_tick7", 32'(tick_num), 32'(e.tick));
                end
            end
        end
    end

    initial begin : main
        logic [7:0] d;
        logic       sv;
        logic [7:0] pat96;

        vt[0] = '{8'hA5, 1'b1, 1'b0, 2, 8'hA5, 1'b0};
        vt[1] = '{8'h00, 1'b1, 1'b1, 0, 8'h00, 1'b0};
        vt[2] = '{8'hFF, 1'b1, 1'b0, 1, 8'hFF, 1'b0};
        vt[3] = '{8'h81, 1'b0, 1'b0, 2, 8'h81, 1'b1};
        vt[4] = '{8'h7E, 1'b1, 1'b1, 3, 8'h7E, 1'b0};

        rst = 1'b1; rx8 = 1'b1; rx7 = 1'b1; s_tick = 1'b0;
        phase = 0; tick_num = 0; last_exp8 = 8'h00;
        repeat (3) step();
        #1;
        check("rst_dout8", 32'(dout8), 32'h0);
        check("rst_ferr8", 32'(ferr8), 32'h0);
        check("rst_done8", 32'(done8), 32'h0);
        check("rst_dout7", 32'(dout7), 32'h0);
        check("rst_ferr7", 32'(ferr7), 32'h0);
        check("rst_done7", 32'(done7), 32'h0);
        rst = 1'b0;
        idle(1'b0, 20);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            send_frame(1'b0, vt[i].data, vt[i].stop_v, 16, vt[i].align,
                       vt[i].exp_dout, vt[i].exp_ferr);
            idle(1'b0, vt[i].gap);
        end
        idle(1'b0, 4);

        // Glitch: 4 ticks low then high, no strobe, dout unchanged, next frame fine
        while (!s_tick) step();
        rx8 = 1'b0;
        hold_ticks(4);
        idle(1'b0, 32);
        check("glitch_dout_hold", 32'(dout8), 32'(last_exp8));
        check("glitch_ferr_hold", 32'(ferr8), 32'h0);
        send_frame(1'b0, 8'hC3, 1'b1, 16, 1'b0, 8'hC3, 1'b0);

        // Framing error followed by a break: one strobe only, then a clean frame
        send_frame(1'b0, 8'h3C, 1'b0, 16 + 48, 1'b0, 8'h3C, 1'b1);
        check("break_ferr_hold", 32'(ferr8), 32'h1);
        idle(1'b0, 16);
        send_frame(1'b0, 8'h11, 1'b1, 16, 1'b0, 8'h11, 1'b0);

        // Back-to-back characters with zero idle time
        send_frame(1'b0, 8'h00, 1'b1, 16, 1'b0, 8'h00, 1'b0);
        send_frame(1'b0, 8'hFF, 1'b1, 16, 1'b0, 8'hFF, 1'b0);
        send_frame(1'b0, 8'h55, 1'b1, 16, 1'b0, 8'h55, 1'b0);
        idle(1'b0, 8);

        // Reset during data bit 3 of 0x96: outputs clear, no strobe, then 0x5A received
        pat96 = 8'h96;
        while (!s_tick) step();
        rx8 = 1'b0;
        hold_ticks(16);
        for (int i = 0; i < 3; i++) begin
            rx8 = pat96[i];
            hold_ticks(16);
        end
        rx8 = pat96[3];
        hold_ticks(8);
        rst = 1'b1;
        #1;
        check("midrst_dout8", 32'(dout8), 32'h0);
        check("midrst_ferr8", 32'(ferr8), 32'h0);
        check("midrst_done8", 32'(done8), 32'h0);
        rx8 = 1'b1;
        repeat (5) step();
        rst = 1'b0;
        idle(1'b0, 32);
        check("postrst_dout8", 32'(dout8), 32'h0);
        send_frame(1'b0, 8'h5A, 1'b1, 16, 1'b0, 8'h5A, 1'b0);

        // Randomized frames on the 8N1 instance against the reference model
        for (int i = 0; i < 6; i++) begin
            d  = 8'($urandom);
            sv = ($urandom_range(0, 3) != 0);
            send_frame(1'b0, d, sv, 16, 1'($urandom_range(0, 1)), ref_char(d, 8), ~sv);
            idle(1'b0, sv ? $urandom_range(0, 3) : $urandom_range(1, 3));
        end

        // 7 data bits, 2 stop bits
        send_frame(1'b1, 8'h2B, 1'b1, 32, 1'b0, 8'h2B, 1'b0);
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            send_frame(1'b1, d, 1'b1, 32, 1'b0, ref_char(d, 7), 1'b0);
            idle(1'b1, $urandom_range(0, 2));
        end
        idle(1'b1, 20);

        check("pending_strobes8", 32'(q8.size()), 32'h0);
        check("pending_strobes7", 32'(q7.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
